// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared types and constants for the DLX write-back stage
//
// Purpose : load-size encodings, datapath width, buffer depth, the zero
//           register index and the buffered-entry record used by wb_stage
//           and its load-alignment helper.
// Ports   : none (package).

package wb_stage_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  // One retiring instruction as held in the skid buffer.
  typedef struct packed {
    logic [4:0]      rd;
    logic            wflag;
    logic [XLEN-1:0] data;
    logic            err;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - combinational load-data lane select and extension
//
// Purpose : picks the addressed byte/half out of the raw memory word, zero- or
//           sign-extends it, and flags misaligned or reserved-size accesses.
// Ports   : ld_size   in  load size encoding (word/half/byte/reserved)
//           ld_signed in  sign-extend sub-word results
//           addr_lo   in  effective address bits [1:0]
//           mem_data  in  raw word from data memory
//           data      out formatted load result
//           err       out access is misaligned or uses the reserved size

module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  ld_size_e        ld_size,
  input  logic            ld_signed,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    case (addr_lo)
      2'd0:    byte_sel = mem_data[7:0];
      2'd1:    byte_sel = mem_data[15:8];
      2'd2:    byte_sel = mem_data[23:16];
      default: byte_sel = mem_data[31:24];
    endcase
  end

  always_comb begin
    data = mem_data;
    err  = 1'b0;
    case (ld_size)
      LD_WORD: begin
        data = mem_data;
        err  = (addr_lo != 2'd0);
      end
      LD_HALF: begin
        data = {{16{ld_signed & half_sel[15]}}, half_sel};
        err  = addr_lo[0];
      end
      LD_BYTE: begin
        data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
        err  = 1'b0;
      end
      default: begin
        // Reserved size: data is irrelevant since the write gets suppressed.
        data = mem_data;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - DLX write-back stage with 2-entry skid buffer
//
// Purpose : accepts retiring instructions from MEM, formats load data at
//           accept time, buffers up to two entries behind a registered
//           in_ready, retires the head to the register-file write port and
//           exposes the head as a forwarding source.
// Config  : WB_RETIRE_CNT_EN adds a 32-bit wrapping retire_count output.
// Ports   : clk, rst (sync, active-low)
//           in_valid/in_ready handshake from MEM plus in_rd, in_regwrite,
//           in_memtoreg, in_alu_result, in_mem_data, in_ld_size,
//           in_ld_signed, in_addr_lo
//           wb_hold        freeze retirement this cycle
//           gpr_we/ws/wdata register-file write port (retire cycle only)
//           fwd_valid/rd/data head entry for the bypass network
//           align_err      pulse when a misaligned load retires
//           retire_count   (WB_RETIRE_CNT_EN only) retired-entry counter

module wb_stage
  import wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic            in_memtoreg,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_signed,
  input  logic [1:0]      in_addr_lo,
  input  logic            wb_hold,
  output logic            gpr_we,
  output logic [4:0]      gpr_ws,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]     retire_count,
`endif
  output logic            align_err
);

  wb_entry_t       buf_q [DEPTH];
  wb_entry_t       buf_d [DEPTH];
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            in_ready_q, in_ready_d;

  logic [XLEN-1:0] ld_data;
  logic            ld_err;
  wb_entry_t       new_entry;
  wb_entry_t       head;
  logic            nonempty;
  logic            accept;
  logic            retire;
  logic            head_writes;

  wb_stage_load_align u_load_align (
    .ld_size   (ld_size_e'(in_ld_size)),
    .ld_signed (in_ld_signed),
    .addr_lo   (in_addr_lo),
    .mem_data  (in_mem_data),
    .data      (ld_data),
    .err       (ld_err)
  );

  // Formatting happens at accept time so the buffer holds final results.
  always_comb begin
    new_entry.rd    = in_rd;
    new_entry.err   = in_memtoreg & ld_err;
    new_entry.wflag = in_regwrite & ~new_entry.err;
    new_entry.data  = in_memtoreg ? ld_data : in_alu_result;
  end

  // Outputs are gated by rst so nothing leaks out during the reset cycle
  // while the buffer registers still hold pre-reset contents.
  always_comb begin
    head        = buf_q[head_q];
    nonempty    = rst & (count_q != 2'd0);
    retire      = nonempty & ~wb_hold;
    accept      = in_valid & in_ready_q;
    head_writes = head.wflag & (head.rd != REG_ZERO);

    gpr_we      = retire & head_writes;
    gpr_ws      = gpr_we ? head.rd : 5'd0;
    gpr_wdata   = gpr_we ? head.data : '0;
    align_err   = retire & head.err;

    fwd_valid   = nonempty & head_writes;
    fwd_rd      = nonempty ? head.rd : 5'd0;
    fwd_data    = nonempty ? head.data : '0;
  end

  always_comb begin
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {1'b0, accept} - {1'b0, retire};
    if (accept) begin
      buf_d[tail_q] = new_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (retire) begin
      head_d = head_q + 1'b1;
    end
    // Ready is registered, so with count at 2 no accept can coincide
    // with the retire that frees a slot.
    in_ready_d = (count_d < 2'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count_q, retire_count_d;

  // Counts every retired entry, misaligned ones included; wraps naturally.
  always_comb begin
    retire_count_d = retire_count_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_count_q <= 32'd0;
    end else begin
      retire_count_q <= retire_count_d;
    end
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [1:0]  in_addr_lo;
  logic        wb_hold;
  logic        gpr_we;
  logic [4:0]  gpr_ws;
  logic [31:0] gpr_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        align_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_regwrite   (in_regwrite),
    .in_memtoreg   (in_memtoreg),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_ld_size    (in_ld_size),
    .in_ld_signed  (in_ld_signed),
    .in_addr_lo    (in_addr_lo),
    .wb_hold       (wb_hold),
    .gpr_we        (gpr_we),
    .gpr_ws        (gpr_ws),
    .gpr_wdata     (gpr_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
`ifdef WB_RETIRE_CNT_EN
    .retire_count  (retire_count),
`endif
    .align_err     (align_err)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic        wflag;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic        m_ready = 1'b1;
  logic [31:0] m_cnt   = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_we, s_ready, s_align, s_fwdv;
  logic [4:0]  s_ws;
  logic [31:0] s_wdata;

  // Reference load formatting from the rules: shift the addressed lane down,
  // mask, then add the sign fill when the top bit of the lane is set.
  function automatic void fmt(input logic [1:0] sz, input logic sg, input logic [1:0] al,
                              input logic [31:0] mem, output logic [31:0] d, output logic e);
    logic [31:0] v;
    int sh;
    case (sz)
      2'd0: begin d = mem; e = (al != 2'd0); end
      2'd1: begin
        sh = al[1] ? 16 : 0;
        v = (mem >> sh) & 32'h0000FFFF;
        if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
        d = v; e = al[0];
      end
      2'd2: begin
        sh = int'(al) * 8;
        v = (mem >> sh) & 32'h000000FF;
        if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
        d = v; e = 1'b0;
      end
      default: begin d = mem; e = 1'b1; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic regw, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] sz,
                      input logic sg, input logic [1:0] al, input logic hold, input logic r);
    ent_t        h, e;
    logic        ne, ok, ret;
    logic [31:0] d;
    logic        er;
    @(negedge clk);
    rst = r; in_valid = v; in_rd = rd; in_regwrite = regw; in_memtoreg = m2r;
    in_alu_result = alu; in_mem_data = mem; in_ld_size = sz; in_ld_signed = sg;
    in_addr_lo = al; wb_hold = hold;
    #1;
    ne  = r && (q.size() > 0);
    h   = ne ? q[0] : '0;
    ok  = ne && h.wflag && (h.rd != 5'd0);
    ret = ne && !hold;
    chk("in_ready",  32'(in_ready),  32'(m_ready));
    chk("gpr_we",    32'(gpr_we),    32'(ok && !hold));
    chk("gpr_ws",    32'(gpr_ws),    (ok && !hold) ? 32'(h.rd) : 32'd0);
    chk("gpr_wdata", gpr_wdata,      (ok && !hold) ? h.data : 32'd0);
    chk("align_err", 32'(align_err), 32'(ret && h.err));
    chk("fwd_valid", 32'(fwd_valid), 32'(ok));
    chk("fwd_rd",    32'(fwd_rd),    ne ? 32'(h.rd) : 32'd0);
    if (ok) chk("fwd_data", fwd_data, h.data);
    else if (!ne) chk("fwd_data_empty", fwd_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, m_cnt);
`endif
    s_we = gpr_we; s_ws = gpr_ws; s_wdata = gpr_wdata; s_ready = in_ready;
    s_align = align_err; s_fwdv = fwd_valid;
    if (!r) begin
      q.delete(); m_ready = 1'b1; m_cnt = 32'd0;
    end else begin
      if (ret) begin void'(q.pop_front()); m_cnt = m_cnt + 32'd1; end
      if (v && m_ready) begin
        fmt(sz, sg, al, mem, d, er);
        e.rd    = rd;
        e.err   = m2r && er;
        e.wflag = regw && !e.err;
        e.data  = m2r ? d : alu;
        q.push_back(e);
      end
      m_ready = (q.size() < 2);
    end
  endtask

  task automatic idle(input logic hold);
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, hold, 1'b1);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input logic hold);
    step(1'b1, rd, 1'b1, 1'b0, val, 32'd0, 2'd0, 1'b0, 2'd0, hold, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic        er;
    rst = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
    in_alu_result = 32'd0; in_mem_data = 32'd0; in_ld_size = 2'd0; in_ld_signed = 1'b0;
    in_addr_lo = 2'd0; wb_hold = 1'b0;

    // Pin the reference formatting with hand-computed values.
    fmt(2'd2, 1'b1, 2'd3, 32'h80FF7F01, d, er); chk("model_lb_s", d, 32'hFFFFFF80);
    fmt(2'd2, 1'b0, 2'd3, 32'h80FF7F01, d, er); chk("model_lb_u", d, 32'h00000080);
    fmt(2'd1, 1'b1, 2'd2, 32'h80FF7F01, d, er); chk("model_lh_s", d, 32'hFFFF80FF);
    fmt(2'd1, 1'b0, 2'd1, 32'h80FF7F01, d, er); chk("model_lh_err", 32'(er), 32'd1);

    // Reset
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("reset_ready", 32'(s_ready), 32'd1);
    chk("reset_we", 32'(s_we), 32'd0);

    // 1: ALU write
    alu_op(5'd5, 32'h12345678, 1'b0);
    idle(1'b0);
    chk("t1_we", 32'(s_we), 32'd1);
    chk("t1_ws", 32'(s_ws), 32'd5);
    chk("t1_wdata", s_wdata, 32'h12345678);

    // 2: byte loads, signed then unsigned
    step(1'b1, 5'd7, 1'b1, 1'b1, 32'd0, 32'h80FF7F01, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1);
    step(1'b1, 5'd8, 1'b1, 1'b1, 32'd0, 32'h80FF7F01, 2'd2, 1'b0, 2'd3, 1'b0, 1'b1);
    chk("t2_signed", s_wdata, 32'hFFFFFF80);
    idle(1'b0);
    chk("t2_unsigned", s_wdata, 32'h00000080);

    // 3: misaligned half, then ALU write to r0
    step(1'b1, 5'd9, 1'b1, 1'b1, 32'd0, 32'hCAFEBABE, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1);
    idle(1'b0);
    chk("t3_mis_we", 32'(s_we), 32'd0);
    chk("t3_mis_err", 32'(s_align), 32'd1);
    idle(1'b0);
    chk("t3_err_once", 32'(s_align), 32'd0);
    alu_op(5'd0, 32'hDEADBEEF, 1'b0);
    idle(1'b0);
    chk("t3_r0_we", 32'(s_we), 32'd0);
    chk("t3_r0_fwd", 32'(s_fwdv), 32'd0);

    // 4: back-to-back with hold
    alu_op(5'd10, 32'hA0A0A0A0, 1'b1);
    alu_op(5'd11, 32'hB1B1B1B1, 1'b1);
    alu_op(5'd12, 32'hC2C2C2C2, 1'b1);
    chk("t4_ready_low", 32'(s_ready), 32'd0);
    alu_op(5'd12, 32'hC2C2C2C2, 1'b0);
    chk("t4_first", 32'(s_ws), 32'd10);
    alu_op(5'd12, 32'hC2C2C2C2, 1'b0);
    chk("t4_second", 32'(s_ws), 32'd11);
    idle(1'b0);
    chk("t4_third", 32'(s_ws), 32'd12);
    idle(1'b0);

    // 5: reset with two entries buffered
    alu_op(5'd13, 32'h13131313, 1'b1);
    alu_op(5'd14, 32'h14141414, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_we_in_rst", 32'(s_we), 32'd0);
    idle(1'b0);
    chk("t5_ready", 32'(s_ready), 32'd1);
    chk("t5_we_after", 32'(s_we), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("t5_count", retire_count, 32'd0);

    // 6: counter wrap
    idle(1'b0);
    @(negedge clk);
    force dut.retire_count_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_count_q;
    m_cnt = 32'hFFFFFFFF;
    alu_op(5'd3, 32'h33333333, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t6_wrap", retire_count, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 9) < 7, rd, 1'($urandom), 1'($urandom), $urandom, $urandom,
           2'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
